// File: rtl/pe_priority_scan.sv
// pe_priority_scan: sequential priority evaluator. It captures one pixel's candidate layers,
// scans them one per cycle and returns the front-most (top) and next (second) visible layers.
// Slots that no layer wins fall back to the backdrop color with layer index NUM_LAYERS.
//
// Ports:
//   clk, rst_b       clock (rising edge), asynchronous active-low reset
//   clear            synchronous abort/flush; discards any job and zeroes results
//   in_valid/ready   job handshake; in_ready is high only in idle with clear low
//   layer_color      packed per-layer colors, layer i at [i*COLOR_WIDTH +: COLOR_WIDTH]
//   layer_prio       packed per-layer priorities, 0 = front-most
//   layer_en         per-layer visible flag
//   backdrop_color   color used for any slot that no layer wins
//   out_valid/ready  result handshake; results are held while out_valid is high
//   top_*/second_*   registered results (color, layer index)
module pe_priority_scan #(
  parameter int unsigned NUM_LAYERS  = 5,
  parameter int unsigned COLOR_WIDTH = 15,
  parameter int unsigned PRIO_WIDTH  = 2,
  parameter int unsigned LAYER_W     = $clog2(NUM_LAYERS + 1)
) (
  input  logic                              clk,
  input  logic                              rst_b,
  input  logic                              clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_LAYERS*COLOR_WIDTH-1:0] layer_color,
  input  logic [NUM_LAYERS*PRIO_WIDTH-1:0]  layer_prio,
  input  logic [NUM_LAYERS-1:0]             layer_en,
  input  logic [COLOR_WIDTH-1:0]            backdrop_color,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [COLOR_WIDTH-1:0]            top_color,
  output logic [LAYER_W-1:0]                top_layer,
  output logic [COLOR_WIDTH-1:0]            second_color,
  output logic [LAYER_W-1:0]                second_layer
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  localparam logic [LAYER_W-1:0] BdLayer = LAYER_W'(NUM_LAYERS);
  localparam logic [LAYER_W-1:0] LastIdx = LAYER_W'(NUM_LAYERS - 1);

  state_e                            state_q, state_d;
  logic [LAYER_W-1:0]                idx_q, idx_d;
  logic [NUM_LAYERS*COLOR_WIDTH-1:0] color_q, color_d;
  logic [NUM_LAYERS*PRIO_WIDTH-1:0]  prio_q, prio_d;
  logic [NUM_LAYERS-1:0]             en_q, en_d;
  logic [COLOR_WIDTH-1:0]            bd_q, bd_d;

  logic [COLOR_WIDTH-1:0] top_color_q, top_color_d, sec_color_q, sec_color_d;
  logic [LAYER_W-1:0]     top_layer_q, top_layer_d, sec_layer_q, sec_layer_d;
  logic [PRIO_WIDTH-1:0]  top_prio_q, top_prio_d, sec_prio_q, sec_prio_d;
  // Slot still holds the backdrop, so any enabled layer beats it regardless of priority.
  logic                   top_bd_q, top_bd_d, sec_bd_q, sec_bd_d;

  logic [COLOR_WIDTH-1:0] cur_color;
  logic [PRIO_WIDTH-1:0]  cur_prio;
  logic                   cur_en;

  // Select the captured layer under evaluation.
  always_comb begin
    cur_color = '0;
    cur_prio  = '0;
    cur_en    = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (idx_q == LAYER_W'(i)) begin
        cur_color = color_q[i*COLOR_WIDTH +: COLOR_WIDTH];
        cur_prio  = prio_q[i*PRIO_WIDTH +: PRIO_WIDTH];
        cur_en    = en_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    color_d     = color_q;
    prio_d      = prio_q;
    en_d        = en_q;
    bd_d        = bd_q;
    top_color_d = top_color_q;
    top_layer_d = top_layer_q;
    top_prio_d  = top_prio_q;
    top_bd_d    = top_bd_q;
    sec_color_d = sec_color_q;
    sec_layer_d = sec_layer_q;
    sec_prio_d  = sec_prio_q;
    sec_bd_d    = sec_bd_q;

    if (clear) begin
      state_d     = StIdle;
      idx_d       = '0;
      top_color_d = '0;
      top_layer_d = '0;
      top_prio_d  = '0;
      top_bd_d    = 1'b0;
      sec_color_d = '0;
      sec_layer_d = '0;
      sec_prio_d  = '0;
      sec_bd_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            color_d     = layer_color;
            prio_d      = layer_prio;
            en_d        = layer_en;
            bd_d        = backdrop_color;
            top_color_d = backdrop_color;
            top_layer_d = BdLayer;
            top_prio_d  = '0;
            top_bd_d    = 1'b1;
            sec_color_d = backdrop_color;
            sec_layer_d = BdLayer;
            sec_prio_d  = '0;
            sec_bd_d    = 1'b1;
            idx_d       = '0;
            state_d     = StScan;
          end
        end
        StScan: begin
          // Strict compares plus ascending scan give lower indices precedence on ties.
          if (cur_en && (top_bd_q || cur_prio < top_prio_q)) begin
            sec_color_d = top_color_q;
            sec_layer_d = top_layer_q;
            sec_prio_d  = top_prio_q;
            sec_bd_d    = top_bd_q;
            top_color_d = cur_color;
            top_layer_d = idx_q;
            top_prio_d  = cur_prio;
            top_bd_d    = 1'b0;
          end else if (cur_en && (sec_bd_q || cur_prio < sec_prio_q)) begin
            sec_color_d = cur_color;
            sec_layer_d = idx_q;
            sec_prio_d  = cur_prio;
            sec_bd_d    = 1'b0;
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      color_q     <= '0;
      prio_q      <= '0;
      en_q        <= '0;
      bd_q        <= '0;
      top_color_q <= '0;
      top_layer_q <= '0;
      top_prio_q  <= '0;
      top_bd_q    <= 1'b0;
      sec_color_q <= '0;
      sec_layer_q <= '0;
      sec_prio_q  <= '0;
      sec_bd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      color_q     <= color_d;
      prio_q      <= prio_d;
      en_q        <= en_d;
      bd_q        <= bd_d;
      top_color_q <= top_color_d;
      top_layer_q <= top_layer_d;
      top_prio_q  <= top_prio_d;
      top_bd_q    <= top_bd_d;
      sec_color_q <= sec_color_d;
      sec_layer_q <= sec_layer_d;
      sec_prio_q  <= sec_prio_d;
      sec_bd_q    <= sec_bd_d;
    end
  end

  assign in_ready     = (state_q == StIdle) && !clear;
  assign out_valid    = (state_q == StDone);
  assign top_color    = top_color_q;
  assign top_layer    = top_layer_q;
  assign second_color = sec_color_q;
  assign second_layer = sec_layer_q;

endmodule

// File: tb/tb_pe_priority_scan.sv
// Scoreboard bench for pe_priority_scan: expected results are queued when a job is driven and
// compared when the DUT hands a result over.
module tb_pe_priority_scan;

  localparam int N  = 5;
  localparam int CW = 15;
  localparam int PW = 2;
  localparam int LW = 3;

  typedef struct packed {
    logic [CW-1:0] tc;
    logic [LW-1:0] tl;
    logic [CW-1:0] sc;
    logic [LW-1:0] sl;
  } res_t;

  logic            clk = 1'b0;
  logic            rst_b, clear, in_valid, in_ready, out_valid, out_ready;
  logic [N*CW-1:0] layer_color;
  logic [N*PW-1:0] layer_prio;
  logic [N-1:0]    layer_en;
  logic [CW-1:0]   backdrop_color, top_color, second_color;
  logic [LW-1:0]   top_layer, second_layer;

  int   n_err = 0;
  int   n_chk = 0;
  int   cyc_cnt = 0;
  res_t exp_q[$];
  int   pop_cyc[$];

  pe_priority_scan #(
    .NUM_LAYERS (N),
    .COLOR_WIDTH(CW),
    .PRIO_WIDTH (PW)
  ) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .layer_color   (layer_color),
    .layer_prio    (layer_prio),
    .layer_en      (layer_en),
    .backdrop_color(backdrop_color),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .top_color     (top_color),
    .top_layer     (top_layer),
    .second_color  (second_color),
    .second_layer  (second_layer)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: pick best enabled layer, then best of the rest (lowest index wins ties).
  function automatic res_t model(input logic [N*CW-1:0] col, input logic [N*PW-1:0] pr,
                                 input logic [N-1:0] en, input logic [CW-1:0] bd);
    res_t r;
    int best = -1;
    int nxt = -1;
    for (int i = 0; i < N; i++)
      if (en[i] && (best < 0 || pr[i*PW +: PW] < pr[best*PW +: PW])) best = i;
    for (int i = 0; i < N; i++)
      if (en[i] && i != best && (nxt < 0 || pr[i*PW +: PW] < pr[nxt*PW +: PW])) nxt = i;
    r.tl = (best < 0) ? LW'(N) : LW'(best);
    r.tc = (best < 0) ? bd : col[best*CW +: CW];
    r.sl = (nxt < 0) ? LW'(N) : LW'(nxt);
    r.sc = (nxt < 0) ? bd : col[nxt*CW +: CW];
    return r;
  endfunction

  // Scoreboard side: compare every accepted result against the queue head.
  always @(negedge clk) begin
    if (rst_b && out_valid && out_ready) begin
      pop_cyc.push_back(cyc_cnt);
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("top_color", top_color, e.tc);
        check("top_layer", top_layer, e.tl);
        check("second_color", second_color, e.sc);
        check("second_layer", second_layer, e.sl);
      end
    end
  end

  task automatic send(input logic [N*CW-1:0] col, input logic [N*PW-1:0] pr,
                      input logic [N-1:0] en, input logic [CW-1:0] bd, input bit push);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    layer_color    = col;
    layer_prio     = pr;
    layer_en       = en;
    backdrop_color = bd;
    in_valid       = 1'b1;
    if (push) exp_q.push_back(model(col, pr, en, bd));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts negedges until out_valid; acceptance-to-valid of N edges shows up as N+1.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) check("out_timeout", 0, 1);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N*CW-1:0] col;
    logic [N*PW-1:0] pr;
    logic [N-1:0]    en;
    res_t            ea;
    int              c;

    rst_b = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    layer_color = '0; layer_prio = '0; layer_en = '0; backdrop_color = '0;
    #22 rst_b = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_results", {top_color, top_layer, second_color, second_layer}, 0);

    // Ordering and tie-break: prio {3,1,2,1,0}, colors 0x10+i.
    for (int i = 0; i < N; i++) col[i*CW +: CW] = CW'(16 + i);
    pr = {2'd0, 2'd1, 2'd2, 2'd1, 2'd3};
    send(col, pr, 5'b11111, 15'h0000, 1'b1);
    wait_out(c);
    check("latency", c, N + 1);
    check("order_top_layer", top_layer, 4);
    check("order_top_color", top_color, 15'h0014);
    check("order_second_layer", second_layer, 1);
    check("order_second_color", second_color, 15'h0011);
    drain();

    // Empty, then single enabled layer.
    send(col, pr, 5'b00000, 15'h7fff, 1'b1);
    wait_out(c);
    check("empty_layers", {top_layer, second_layer}, {3'd5, 3'd5});
    check("empty_colors", {top_color, second_color}, {15'h7fff, 15'h7fff});
    pr = 10'b00_00_11_00_00;
    send(col, pr, 5'b00100, 15'h7fff, 1'b1);
    wait_out(c);
    check("single_layers", {top_layer, second_layer}, {3'd2, 3'd5});
    drain();

    // Backpressure: hold DONE with a new job waiting on the input.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) col[i*CW +: CW] = CW'(15'h100 + 3 * i);
    pr = {2'd2, 2'd2, 2'd0, 2'd3, 2'd1};
    ea = model(col, pr, 5'b11011, 15'h0abc);
    send(col, pr, 5'b11011, 15'h0abc, 1'b1);
    wait_out(c);
    for (int i = 0; i < N; i++) col[i*CW +: CW] = CW'(15'h200 + i);
    pr = {2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    layer_color = col; layer_prio = pr; layer_en = 5'b01110; backdrop_color = 15'h0123;
    in_valid = 1'b1;
    exp_q.push_back(model(col, pr, 5'b01110, 15'h0123));
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", {top_color, top_layer, second_color, second_layer}, ea);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_in_ready", in_ready, 1);
    check("bp_idle_out_valid", out_valid, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_accepted", in_ready, 0);
    wait_out(c);
    drain();

    // Clear on the third SCAN cycle: job vanishes, next job is clean.
    send(col, pr, 5'b11111, 15'h0555, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 clear = 1'b1;
    @(negedge clk);
    check("clr_in_ready", in_ready, 0);
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("clr_idle", in_ready, 1);
    check("clr_zeroed", {top_color, top_layer, second_color, second_layer}, 0);
    c = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) c++;
      @(negedge clk);
    end
    check("clr_no_valid", c, 0);
    pr = {2'd3, 2'd0, 2'd2, 2'd0, 2'd3};
    send(col, pr, 5'b10111, 15'h0666, 1'b1);
    wait_out(c);
    drain();

    // Back-to-back random jobs at full rate.
    pop_cyc.delete();
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < N; i++) begin
        col[i*CW +: CW] = CW'($urandom);
        pr[i*PW +: PW]  = PW'($urandom);
      end
      en = N'($urandom);
      send(col, pr, en, CW'($urandom), 1'b1);
    end
    drain();
    check("b2b_count", pop_cyc.size(), 4);
    for (int i = 1; i < pop_cyc.size(); i++) check("b2b_spacing", pop_cyc[i] - pop_cyc[i-1], 7);

    // Asynchronous reset mid-SCAN.
    send(col, pr, 5'b11111, 15'h0777, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_results", {top_color, top_layer, second_color, second_layer}, 0);
    #4 rst_b = 1'b1;
    @(negedge clk);
    check("arst_in_ready", in_ready, 1);
    pr = {2'd1, 2'd3, 2'd0, 2'd2, 2'd0};
    send(col, pr, 5'b11110, 15'h0042, 1'b1);
    wait_out(c);
    drain();
    check("no_extra_results", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
